// File: rtl/plab5_mcore_resp_net_arbiter.sv
// Round-robin arbiter merging per-bank response messages into one network port through a one-entry output buffer.
// Optional macro PLAB5_MCORE_RESP_ARB_DOMAIN_GAP_EN inserts one idle slot on every security-domain switch.
module plab5_mcore_resp_net_arbiter #(
  parameter int unsigned p_num_reqs   = 4,
  parameter int unsigned p_ctrl_nbits = 23,
  parameter int unsigned p_data_nbits = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [p_num_reqs-1:0]                in_val,
  output logic [p_num_reqs-1:0]                in_rdy,
  input  logic [p_num_reqs-1:0]                in_domain,
  input  logic [p_num_reqs*p_ctrl_nbits-1:0]   in_msg_control,
  input  logic [p_num_reqs*p_data_nbits-1:0]   in_msg_data,
  output logic                                 out_val,
  input  logic                                 out_rdy,
  output logic                                 out_domain,
  output logic [p_ctrl_nbits-1:0]              out_msg_control,
  output logic [p_data_nbits-1:0]              out_msg_data
);

  localparam int unsigned PTR_W = $clog2(p_num_reqs);

  logic                    out_val_q,  out_val_d;
  logic                    out_dom_q,  out_dom_d;
  logic [p_ctrl_nbits-1:0] out_ctrl_q, out_ctrl_d;
  logic [p_data_nbits-1:0] out_data_q, out_data_d;
  logic [PTR_W-1:0]        ptr_q,      ptr_d;

`ifdef PLAB5_MCORE_RESP_ARB_DOMAIN_GAP_EN
  logic last_dom_q,  last_dom_d;
  logic have_xfer_q, have_xfer_d;
  logic gap_paid_q,  gap_paid_d;
  logic gap_c;
`endif

  logic [p_num_reqs-1:0]   grant;
  logic                    found;
  logic [PTR_W-1:0]        win_idx;
  logic [PTR_W-1:0]        scan_idx;
  logic                    sel_dom;
  logic [p_ctrl_nbits-1:0] sel_ctrl;
  logic [p_data_nbits-1:0] sel_data;
  logic                    can_load;
  logic                    load_ok;
  logic                    xfer;

  // Rotating priority scan starting at ptr_q; the index wraps by truncation.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < int'(p_num_reqs); k++) begin
      scan_idx = ptr_q + PTR_W'(k);
      if (!found && in_val[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        win_idx         = scan_idx;
      end
    end
  end

  // Payload mux driven by the one-hot grant.
  always_comb begin
    sel_dom  = 1'b0;
    sel_ctrl = '0;
    sel_data = '0;
    for (int i = 0; i < int'(p_num_reqs); i++) begin
      if (grant[i]) begin
        sel_dom  = in_domain[i];
        sel_ctrl = in_msg_control[i*p_ctrl_nbits +: p_ctrl_nbits];
        sel_data = in_msg_data[i*p_data_nbits +: p_data_nbits];
      end
    end
  end

  always_comb begin
    out_val_d  = out_val_q;
    out_dom_d  = out_dom_q;
    out_ctrl_d = out_ctrl_q;
    out_data_d = out_data_q;
    ptr_d      = ptr_q;
    can_load   = !out_val_q || out_rdy;
    load_ok    = !reset && can_load && found;
`ifdef PLAB5_MCORE_RESP_ARB_DOMAIN_GAP_EN
    last_dom_d  = last_dom_q;
    have_xfer_d = have_xfer_q;
    gap_paid_d  = gap_paid_q;
    // The cycle in which a domain switch is first seen is the idle GAP slot.
    gap_c       = load_ok && have_xfer_q && !gap_paid_q && (sel_dom != last_dom_q);
    xfer        = load_ok && !gap_c;
`else
    xfer        = load_ok;
`endif
    in_rdy = xfer ? grant : '0;

    if (xfer) begin
      out_val_d  = 1'b1;
      out_dom_d  = sel_dom;
      out_ctrl_d = sel_ctrl;
      out_data_d = sel_data;
      ptr_d      = win_idx + PTR_W'(1);
    end else if (out_rdy) begin
      out_val_d  = 1'b0;
    end

`ifdef PLAB5_MCORE_RESP_ARB_DOMAIN_GAP_EN
    if (xfer) begin
      last_dom_d  = sel_dom;
      have_xfer_d = 1'b1;
      gap_paid_d  = 1'b0;
    end else if (gap_c) begin
      gap_paid_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_val_q   <= 1'b0;
      out_dom_q   <= 1'b0;
      out_ctrl_q  <= '0;
      out_data_q  <= '0;
      ptr_q       <= '0;
`ifdef PLAB5_MCORE_RESP_ARB_DOMAIN_GAP_EN
      last_dom_q  <= 1'b0;
      have_xfer_q <= 1'b0;
      gap_paid_q  <= 1'b0;
`endif
    end else begin
      out_val_q   <= out_val_d;
      out_dom_q   <= out_dom_d;
      out_ctrl_q  <= out_ctrl_d;
      out_data_q  <= out_data_d;
      ptr_q       <= ptr_d;
`ifdef PLAB5_MCORE_RESP_ARB_DOMAIN_GAP_EN
      last_dom_q  <= last_dom_d;
      have_xfer_q <= have_xfer_d;
      gap_paid_q  <= gap_paid_d;
`endif
    end
  end

  assign out_val         = out_val_q;
  assign out_domain      = out_dom_q;
  assign out_msg_control = out_ctrl_q;
  assign out_msg_data    = out_data_q;

endmodule
